// File: rtl/rr_put_controller_if.sv
// rtl/rr_put_controller_if.sv - request/grant and FIFO-side signal bundle for rr_put_controller
interface rr_put_controller_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]            req_put;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic                         get_done;
    logic [NUM_CH-1:0]            grant;
    logic                         en_put;
    logic [DATA_WIDTH-1:0]        put_data;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         empty;

    modport master (
        output req_put, data_in, get_done,
        input  grant, en_put, put_data, count, full, empty
    );

    modport slave (
        input  req_put, data_in, get_done,
        output grant, en_put, put_data, count, full, empty
    );
endinterface

// File: rtl/rr_put_controller.sv
// rtl/rr_put_controller.sv - round-robin put arbiter tracking downstream FIFO occupancy
// Optional macro RR_PUT_CTRL_STATS_EN adds a saturating 16-bit stall_cnt output.
module rr_put_controller #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rr_put_controller_if.slave    bus
`ifdef RR_PUT_CTRL_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      last_ptr;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_found;
    logic [NUM_CH-1:0]     grant_c;
    logic                  xfer;
    logic                  dec;
    logic                  en_put_r;
    logic [DATA_WIDTH-1:0] put_data_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_c;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return PTR_W'(s);
    endfunction

    assign full_c = (count_r == FULL_CNT);

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_c   = '0;
        win_idx   = last_ptr;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!win_found && bus.req_put[wrap_idx(last_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(last_ptr, k);
            end
        end
        if (win_found && !reset && !full_c) grant_c[win_idx] = 1'b1;
    end

    assign xfer = |grant_c;
    assign dec  = bus.get_done && (count_r != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_put_r   <= 1'b0;
            put_data_r <= '0;
            count_r    <= '0;
            last_ptr   <= PTR_W'(NUM_CH - 1);
        end else begin
            en_put_r <= xfer;
            if (xfer) begin
                put_data_r <= bus.data_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                last_ptr   <= win_idx;
            end
            if (xfer && !dec)
                count_r <= count_r + 1'b1;
            else if (!xfer && dec)
                count_r <= count_r - 1'b1;
        end
    end

`ifdef RR_PUT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if ((|bus.req_put) && !xfer && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign bus.grant    = grant_c;
    assign bus.en_put   = en_put_r;
    assign bus.put_data = put_data_r;
    assign bus.count    = count_r;
    assign bus.full     = full_c;
    assign bus.empty    = (count_r == '0);
endmodule

// File: tb/tb_rr_put_controller.sv
// tb/tb_rr_put_controller.sv - directed self-checking bench for rr_put_controller
module tb_rr_put_controller;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_put_controller_if #(.NUM_CH(4), .DATA_WIDTH(8), .DEPTH(16)) bus();
`ifdef RR_PUT_CTRL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    rr_put_controller #(.NUM_CH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef RR_PUT_CTRL_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    logic [3:0] grant_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] data_seq  [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3,
                                  8'hA0, 8'hA1, 8'hA2, 8'hA3};

    initial begin
        bus.req_put  = 4'b1111;
        bus.data_in  = 32'hA3A2A1A0;
        bus.get_done = 1'b0;
        settle;
        check("grant_in_reset", 32'(bus.grant), 32'h0);
        tick;
        tick;
        check("rst_en_put", 32'(bus.en_put), 32'h0);
        check("rst_put_data", 32'(bus.put_data), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_empty", 32'(bus.empty), 32'h1);
        check("rst_full", 32'(bus.full), 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle;
            check("rr_grant", 32'(bus.grant), 32'(grant_seq[i]));
            tick;
            check("rr_en_put", 32'(bus.en_put), 32'h1);
            check("rr_put_data", 32'(bus.put_data), 32'(data_seq[i]));
            check("rr_count", 32'(bus.count), 32'(i + 1));
        end

        bus.req_put = 4'b0000;
        settle;
        check("idle_grant", 32'(bus.grant), 32'h0);
        tick;
        check("idle_en_put", 32'(bus.en_put), 32'h0);
        check("idle_hold_data", 32'(bus.put_data), 32'hA3);
        check("idle_count", 32'(bus.count), 32'd8);

        bus.req_put = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            settle;
            check("fill_grant", 32'(bus.grant), 32'h1);
            tick;
        end
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_full", 32'(bus.full), 32'h1);
        settle;
        check("full_grant", 32'(bus.grant), 32'h0);
        bus.get_done = 1'b1;
        settle;
        check("full_grant_gd", 32'(bus.grant), 32'h0);
        tick;
        check("full_pop_count", 32'(bus.count), 32'd15);
        check("full_pop_en_put", 32'(bus.en_put), 32'h0);
        check("full_pop_full", 32'(bus.full), 32'h0);
        bus.get_done = 1'b0;
        settle;
        check("resume_grant", 32'(bus.grant), 32'h1);
        tick;
        check("refill_count", 32'(bus.count), 32'd16);

        bus.req_put  = 4'b0000;
        bus.get_done = 1'b1;
        repeat (11) tick;
        check("drain5_count", 32'(bus.count), 32'd5);
        bus.req_put = 4'b0100;
        settle;
        check("both_grant", 32'(bus.grant), 32'h4);
        tick;
        check("both_count", 32'(bus.count), 32'd5);
        check("both_en_put", 32'(bus.en_put), 32'h1);
        check("both_put_data", 32'(bus.put_data), 32'hA2);

        bus.get_done = 1'b0;
        bus.req_put  = 4'b1000;
        settle;
        check("ch3_grant", 32'(bus.grant), 32'h8);
        tick;
        bus.data_in[23:16] = 8'h5C;
        bus.req_put = 4'b0100;
        settle;
        check("ch2_after_ch3", 32'(bus.grant), 32'h4);
        tick;
        check("ch2_put_data", 32'(bus.put_data), 32'h5C);
        check("ch2_count", 32'(bus.count), 32'd7);

        bus.req_put  = 4'b0000;
        bus.get_done = 1'b1;
        repeat (7) tick;
        check("drain0_count", 32'(bus.count), 32'd0);
        tick;
        check("underflow_count", 32'(bus.count), 32'd0);
        check("underflow_empty", 32'(bus.empty), 32'h1);

        bus.get_done = 1'b0;
        bus.req_put  = 4'b0001;
        tick;
        check("pre_rst_en_put", 32'(bus.en_put), 32'h1);
        check("pre_rst_count", 32'(bus.count), 32'd1);
        reset = 1'b1;
        bus.get_done = 1'b1;
        settle;
        check("mid_rst_grant", 32'(bus.grant), 32'h0);
        tick;
        check("mid_rst_en_put", 32'(bus.en_put), 32'h0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_data", 32'(bus.put_data), 32'h0);
        check("mid_rst_empty", 32'(bus.empty), 32'h1);
        check("mid_rst_full", 32'(bus.full), 32'h0);
        reset = 1'b0;
        bus.get_done = 1'b0;
        bus.req_put  = 4'b1111;
        settle;
        check("post_rst_prio", 32'(bus.grant), 32'h1);
        tick;

`ifdef RR_PUT_CTRL_STATS_EN
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.req_put = 4'b0001;
        repeat (16) tick;
        check("stat_full", 32'(bus.full), 32'h1);
        check("stat_zero", 32'(stall_cnt), 32'h0);
        repeat (20) tick;
        check("stat_20", 32'(stall_cnt), 32'd20);
        repeat (70000) tick;
        check("stat_sat", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_put_controller.md
RR_PUT_CONTROLLER -- requirements
Module: rr_put_controller

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, width of one put word.
REQ-003 Parameter DEPTH, default 16, capacity of downstream FIFO in words (power of 2, 2..256).
REQ-004 Derived CNT_W = clog2(DEPTH+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_put  in  NUM_CH  per-channel put request; one word per cycle while high.
REQ-008 data_in  in  NUM_CH*DATA_WIDTH  channel i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 get_done  in  1  downstream FIFO popped one word this cycle.
REQ-010 grant  out  NUM_CH  one-hot combinational acceptance; req_put[i]&grant[i] at an edge = transfer.
REQ-011 en_put  out  1  registered FIFO write enable.
REQ-012 put_data  out  DATA_WIDTH  registered word accompanying en_put.
REQ-013 count  out  CNT_W  registered FIFO occupancy tracked by this block.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-015 grant SHALL be at most one-hot, zero when reset=1, when count==DEPTH, or when no req_put bit is high.
REQ-016 Arbitration SHALL be round-robin: search starts at channel (last_ptr+1) mod NUM_CH; first requesting channel wins.
REQ-017 last_ptr SHALL update to the winning index only on a granted cycle; unchanged otherwise.
REQ-018 Latency: a transfer at edge t SHALL produce en_put=1 and put_data=winner's data_in during cycle t+1 (exactly one cycle).
REQ-019 en_put SHALL be 0 in any cycle following an edge with no transfer; put_data holds its last value then.
REQ-020 count SHALL update at the same edge as the transfer: +1 on transfer only, -1 on get_done only, unchanged on both or neither.
REQ-021 get_done while count==0 SHALL be ignored (no underflow).
REQ-022 Full: no grant at count==DEPTH even if get_done is high that cycle; grant resumes the cycle after count drops.
REQ-023 A continuously requesting channel SHALL receive grant at least once every NUM_CH granted cycles.
REQ-024 A requester SHALL NOT be acknowledged other than via grant; dropping req_put without grant loses nothing.

Reset
REQ-025 reset=1 at an edge SHALL clear: en_put=0, put_data=0, count=0, last_ptr=NUM_CH-1 (so channel 0 has first priority).
REQ-026 Reset mid-operation SHALL discard any pending put and cancel en_put the following cycle; get_done ignored during reset.
REQ-027 full=0 and empty=1 SHALL hold from the first cycle after reset.

Configuration
REQ-028 Macro RR_PUT_CTRL_STATS_EN SHALL, when defined, add output stall_cnt (16 bits): +1 each cycle any req_put bit is high and grant is zero, saturating at 16'hFFFF, cleared by reset.
REQ-029 Without RR_PUT_CTRL_STATS_EN the stall_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then req_put=4'b1111 held 8 cycles, no get_done -> grant sequence ch0,1,2,3,0,1,2,3; en_put high cycles 2..9; count=8.
REQ-031 Fill to count=16, req_put=4'b0001 -> grant=0, full=1; one get_done -> count=15, next cycle grant=4'b0001, count returns to 16.
REQ-032 count=5, transfer and get_done same cycle -> count stays 5, en_put=1 next cycle with correct put_data.
REQ-033 count=0, get_done=1 -> count stays 0, empty=1; reset asserted mid-stream with en_put pending -> en_put=0, count=0 next cycle.
REQ-034 Only ch2 requesting after ch3 last granted -> ch2 granted immediately; put_data equals data_in[23:16] one cycle later.
REQ-035 With RR_PUT_CTRL_STATS_EN, 20 blocked cycles at full -> stall_cnt=20; forced 70000 blocked cycles -> stall_cnt=16'hFFFF.
